// File: rtl/packet_action_fifo.sv
// ----------------------------------------------------------------------------
// packet_action_fifo
//
// Store-and-forward packet FIFO with a separate per-packet action queue.
// A packet is released only after its last word is stored and an action has
// been paired with it. The action either forwards the packet with the action
// attached on rd_action, or discards the whole packet in a single cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_valid/wr_ready           input word handshake
//   wr_data, wr_keep, wr_last   input word, byte enables, end of packet
//   act_valid/act_ready         action handshake
//   act_data                    action for the oldest packet lacking one
//   rd_valid/rd_ready           output word handshake (registered outputs)
//   rd_data, rd_keep, rd_last   output word, byte enables, end of packet
//   rd_sop                      first word of a packet
//   rd_action                   action of the packet being sent
//   pkt_count                   complete packets stored, not yet launched
//   drop_count                  packets dropped, saturating
// ----------------------------------------------------------------------------
module packet_action_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 512,
    parameter int PKT_DEPTH = 32,
    parameter int ACTION_W  = 64,
    parameter int DROP_BIT  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_keep,
    input  logic                       wr_last,
    output logic                       wr_ready,
    input  logic                       act_valid,
    input  logic [ACTION_W-1:0]        act_data,
    output logic                       act_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [DATA_W/8-1:0]        rd_keep,
    output logic                       rd_last,
    output logic                       rd_sop,
    output logic [ACTION_W-1:0]        rd_action,
    input  logic                       rd_ready,
    output logic [$clog2(PKT_DEPTH):0] pkt_count,
    output logic [15:0]                drop_count
);

    localparam int KEEP_W  = DATA_W / 8;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PADDR_W = $clog2(PKT_DEPTH);

    localparam logic [ADDR_W:0]    DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    ONE_W     = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W:0]    ZERO_W    = (ADDR_W + 1)'(1'b0);
    localparam logic [PADDR_W:0]   PKT_CNT   = (PADDR_W + 1)'(PKT_DEPTH);
    localparam logic [PADDR_W:0]   ONE_P     = (PADDR_W + 1)'(1'b1);
    localparam logic [PADDR_W:0]   ZERO_P    = (PADDR_W + 1)'(1'b0);
    localparam logic [PADDR_W-1:0] PTR_ONE   = PADDR_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Storage (not reset)
    logic [KEEP_W+DATA_W-1:0] mem_r      [DEPTH];
    logic [ADDR_W:0]          desc_end_r [PKT_DEPTH];
    logic [ADDR_W:0]          desc_len_r [PKT_DEPTH];
    logic [ACTION_W-1:0]      act_mem_r  [PKT_DEPTH];

    // Pointers and occupancy
    logic [ADDR_W:0]    wr_ptr_r;
    logic [ADDR_W:0]    rd_ptr_r;
    logic [ADDR_W:0]    words_used_r;
    logic [ADDR_W:0]    words_used_s;
    logic [ADDR_W:0]    cur_len_r;
    logic [PADDR_W-1:0] desc_wr_ptr_r;
    logic [PADDR_W-1:0] desc_rd_ptr_r;
    logic [PADDR_W:0]   desc_used_r;
    logic [PADDR_W:0]   desc_used_s;
    logic [PADDR_W-1:0] act_wr_ptr_r;
    logic [PADDR_W-1:0] act_rd_ptr_r;
    logic [PADDR_W:0]   act_used_r;
    logic [PADDR_W:0]   act_used_s;

    // Output register
    logic                 rd_valid_r;
    logic [DATA_W-1:0]    rd_data_r;
    logic [KEEP_W-1:0]    rd_keep_r;
    logic                 rd_last_r;
    logic                 rd_sop_r;
    logic [ACTION_W-1:0]  rd_action_r;
    logic [ADDR_W:0]      cur_end_r;
    logic [15:0]          drop_count_r;

    // Control
    state_t               state_r;
    state_t               state_s;
    logic                 launch_s;
    logic                 advance_s;
    logic                 finish_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 eligible_s;
    logic                 wr_ready_s;
    logic                 act_ready_s;
    logic                 wr_fire_s;
    logic                 desc_push_s;
    logic                 act_fire_s;
    logic                 rd_fire_s;
    logic [ADDR_W:0]      desc_end_head_s;
    logic [ADDR_W:0]      desc_len_head_s;
    logic [ACTION_W-1:0]  act_head_s;
    logic [KEEP_W+DATA_W-1:0] mem_word_s;

    assign wr_ready_s      = (words_used_r < DEPTH_CNT) && (desc_used_r < PKT_CNT);
    assign act_ready_s     = act_used_r < PKT_CNT;
    assign wr_fire_s       = wr_valid && wr_ready_s;
    assign desc_push_s     = wr_fire_s && wr_last;
    assign act_fire_s      = act_valid && act_ready_s;
    assign rd_fire_s       = rd_valid_r && rd_ready;
    assign eligible_s      = (desc_used_r != ZERO_P) && (act_used_r != ZERO_P);
    assign pop_s           = launch_s || drop_s;
    assign desc_end_head_s = desc_end_r[desc_rd_ptr_r];
    assign desc_len_head_s = desc_len_r[desc_rd_ptr_r];
    assign act_head_s      = act_mem_r[act_rd_ptr_r];
    assign mem_word_s      = mem_r[rd_ptr_r[ADDR_W-1:0]];

    // Storage writes: data words, descriptors on last word, actions.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= {wr_keep, wr_data};
        end
        if (desc_push_s) begin
            desc_end_r[desc_wr_ptr_r] <= wr_ptr_r;
            desc_len_r[desc_wr_ptr_r] <= cur_len_r + ONE_W;
        end
        if (act_fire_s) begin
            act_mem_r[act_wr_ptr_r] <= act_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        state_s   = state_r;
        launch_s  = 1'b0;
        advance_s = 1'b0;
        finish_s  = 1'b0;
        drop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (eligible_s) begin
                    if (act_head_s[DROP_BIT]) begin
                        state_s = ST_DROP;
                    end else begin
                        launch_s = 1'b1;
                        state_s  = ST_SEND;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (rd_fire_s) begin
                    if (rd_last_r) begin
                        finish_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DROP: begin
                drop_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy next values; write, read handshake and drop all net in one cycle.
    always_comb begin
        words_used_s = words_used_r
                     + (wr_fire_s ? ONE_W : ZERO_W)
                     - (rd_fire_s ? ONE_W : ZERO_W)
                     - (drop_s ? desc_len_head_s : ZERO_W);
        desc_used_s  = desc_used_r
                     + (desc_push_s ? ONE_P : ZERO_P)
                     - (pop_s ? ONE_P : ZERO_P);
        act_used_s   = act_used_r
                     + (act_fire_s ? ONE_P : ZERO_P)
                     - (pop_s ? ONE_P : ZERO_P);
    end

    // Write-side pointers, current packet length and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= ZERO_W;
            cur_len_r     <= ZERO_W;
            words_used_r  <= ZERO_W;
            desc_wr_ptr_r <= '0;
            desc_rd_ptr_r <= '0;
            desc_used_r   <= ZERO_P;
            act_wr_ptr_r  <= '0;
            act_rd_ptr_r  <= '0;
            act_used_r    <= ZERO_P;
        end else begin
            words_used_r <= words_used_s;
            desc_used_r  <= desc_used_s;
            act_used_r   <= act_used_s;
            if (wr_fire_s) begin
                wr_ptr_r  <= wr_ptr_r + ONE_W;
                cur_len_r <= wr_last ? ZERO_W : (cur_len_r + ONE_W);
            end
            if (desc_push_s) begin
                desc_wr_ptr_r <= desc_wr_ptr_r + PTR_ONE;
            end
            if (act_fire_s) begin
                act_wr_ptr_r <= act_wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                desc_rd_ptr_r <= desc_rd_ptr_r + PTR_ONE;
                act_rd_ptr_r  <= act_rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Output register and read pointer. rd_last is computed when a word is
    // loaded by comparing its address with the packet's end pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r    <= ZERO_W;
            cur_end_r   <= ZERO_W;
            rd_valid_r  <= 1'b0;
            rd_sop_r    <= 1'b0;
            rd_last_r   <= 1'b0;
            rd_data_r   <= '0;
            rd_keep_r   <= '0;
            rd_action_r <= '0;
        end else if (launch_s) begin
            rd_valid_r  <= 1'b1;
            rd_sop_r    <= 1'b1;
            rd_last_r   <= (rd_ptr_r == desc_end_head_s);
            {rd_keep_r, rd_data_r} <= mem_word_s;
            rd_action_r <= act_head_s;
            cur_end_r   <= desc_end_head_s;
            rd_ptr_r    <= rd_ptr_r + ONE_W;
        end else if (advance_s) begin
            rd_sop_r    <= 1'b0;
            rd_last_r   <= (rd_ptr_r == cur_end_r);
            {rd_keep_r, rd_data_r} <= mem_word_s;
            rd_ptr_r    <= rd_ptr_r + ONE_W;
        end else if (finish_s) begin
            rd_valid_r  <= 1'b0;
            rd_sop_r    <= 1'b0;
            rd_last_r   <= 1'b0;
        end else if (drop_s) begin
            rd_ptr_r    <= desc_end_head_s + ONE_W;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_r <= 16'h0000;
        end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end
    end

    assign wr_ready   = wr_ready_s;
    assign act_ready  = act_ready_s;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign rd_keep    = rd_keep_r;
    assign rd_last    = rd_last_r;
    assign rd_sop     = rd_sop_r;
    assign rd_action  = rd_action_r;
    assign pkt_count  = desc_used_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_packet_action_fifo.sv
// ----------------------------------------------------------------------------
// tb_packet_action_fifo
//
// Directed bench for packet_action_fifo with default parameters. Expected
// output beats are queued as packets are written (forwarded packets only) and
// a monitor pops and compares them on every output handshake.
// ----------------------------------------------------------------------------
module tb_packet_action_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic [0:0]  wr_keep;
    logic        wr_last;
    logic        wr_ready;
    logic        act_valid;
    logic [63:0] act_data;
    logic        act_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [0:0]  rd_keep;
    logic        rd_last;
    logic        rd_sop;
    logic [63:0] rd_action;
    logic        rd_ready;
    logic [5:0]  pkt_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    packet_action_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_keep    (wr_keep),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .act_valid  (act_valid),
        .act_data   (act_data),
        .act_ready  (act_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_keep    (rd_keep),
        .rd_last    (rd_last),
        .rd_sop     (rd_sop),
        .rd_action  (rd_action),
        .rd_ready   (rd_ready),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic [0:0]  keep;
        logic        last;
        logic        sop;
        logic [63:0] action;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    last_end_cyc = 0;
    int    gap_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compare each handshaked output beat.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        if (rst_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            got = '{data: rd_data, keep: rd_keep, last: rd_last, sop: rd_sop, action: rd_action};
            if (got.sop) gap_cyc = cyc - last_end_cyc;
            if (got.last) last_end_cyc = cyc;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_beat observed=%0h expected=none", got);
            end
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                chk("beat", got, exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_keep  = d[0];
        wr_last  = l;
        while (wr_ready !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk("wr_timeout", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic put_act(input logic [63:0] a);
        int t;
        t = 0;
        act_valid = 1'b1;
        act_data  = a;
        while (act_ready !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk("act_timeout", act_ready, 1'b1);
        tick();
        act_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] base, input int len, input logic [63:0] a);
        logic [7:0] d;
        if (!a[0]) begin
            for (int j = 0; j < len; j++) begin
                d = base + 8'(j);
                exp_q.push_back('{data: d, keep: d[0], last: (j == len - 1), sop: (j == 0), action: a});
            end
        end
    endtask

    task automatic write_words(input logic [7:0] base, input int from, input int to, input int len);
        for (int j = from; j < to; j++) put_word(base + 8'(j), j == len - 1);
    endtask

    task automatic put_pkt(input logic [7:0] base, input int len, input logic [63:0] a);
        push_exp(base, len, a);
        write_words(base, 0, len, len);
    endtask

    task automatic wait_drain(input int target, input string tag);
        int t;
        t = 0;
        while ((exp_q.size() > target || (target == 0 && rd_valid === 1'b1)) && t < 2000) begin
            tick();
            t++;
        end
        chk(tag, t < 2000, 1'b1);
    endtask

    initial begin
        int seen;
        logic [3:0] pat;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_keep = 1'b0; wr_last = 1'b0;
        act_valid = 1'b0; act_data = 64'h0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_sop", rd_sop, 1'b0);
        chk("rst_rd_last", rd_last, 1'b0);
        chk("rst_rd_data", {rd_keep, rd_data}, 9'h000);
        chk("rst_rd_action", rd_action, 64'h0);
        chk("rst_pkt_count", pkt_count, 6'd0);
        chk("rst_drop_count", drop_count, 16'h0000);
        chk("rst_wr_ready", {wr_ready, act_ready}, 2'b11);
        #2 rst_n = 1'b1;
        tick();

        // Basic forward with latency check
        rd_ready = 1'b1;
        put_act(64'hA0);
        put_pkt(8'h11, 4, 64'hA0);
        chk("lat_edge_n", rd_valid, 1'b0);
        tick();
        chk("lat_edge_n1", {rd_valid, rd_sop, rd_data}, {1'b1, 1'b1, 8'h11});
        chk("lat_action", rd_action, 64'hA0);
        wait_drain(0, "drain_basic");

        // Back-to-back forwarded packets: exactly one idle cycle
        rd_ready = 1'b0;
        put_act(64'hB0);
        put_act(64'hC0);
        put_pkt(8'h51, 2, 64'hB0);
        put_pkt(8'h61, 3, 64'hC0);
        rd_ready = 1'b1;
        wait_drain(0, "drain_b2b");
        chk("idle_gap", gap_cyc, 2);

        // Stall pattern 1,0,0,1 with hold check
        rd_ready = 1'b0;
        put_act(64'hA0);
        put_pkt(8'h11, 4, 64'hA0);
        pat = 4'b1001;
        for (int i = 0; i < 60 && (exp_q.size() > 0 || rd_valid === 1'b1); i++) begin
            rd_ready = pat[i % 4];
            if (rd_valid === 1'b1 && rd_ready === 1'b0 && exp_q.size() > 0)
                chk("stall_hold", rd_data, exp_q[0].data);
            tick();
        end
        chk("stall_done", exp_q.size(), 0);
        rd_ready = 1'b1;
        wait_drain(0, "drain_stall");

        // Forward / drop / forward
        put_act(64'h0);
        put_act(64'h1);
        put_act(64'h0);
        put_pkt(8'h71, 2, 64'h0);
        put_pkt(8'h81, 2, 64'h1);
        put_pkt(8'h91, 2, 64'h0);
        repeat (4) tick();
        wait_drain(0, "drain_drop");
        chk("drop_count", drop_count, 16'd1);
        chk("drop_pkt_count", pkt_count, 6'd0);
        chk("drop_words_used", dut.words_used_r, 10'd0);

        // Packet waits for its action
        put_pkt(8'hD1, 3, 64'hD0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (rd_valid === 1'b1) seen = 1;
            tick();
        end
        chk("noact_valid", seen, 0);
        chk("noact_pkt_count", pkt_count, 6'd1);
        put_act(64'hD0);
        chk("act_lat_m", rd_valid, 1'b0);
        tick();
        chk("act_lat_m1", {rd_valid, rd_sop, rd_data}, {1'b1, 1'b1, 8'hD1});
        wait_drain(0, "drain_noact");

        // Fill the data store: 30 x 17-word packets + 2 words of a 31st
        rd_ready = 1'b0;
        for (int i = 0; i < 30; i++) put_pkt(8'(i * 17), 17, 64'(256 + 2 * i));
        push_exp(8'(30 * 17), 17, 64'(256 + 60));
        write_words(8'(30 * 17), 0, 2, 17);
        chk("full_words_used", dut.words_used_r, 10'd512);
        chk("full_wr_ready", wr_ready, 1'b0);
        rd_ready = 1'b1;
        put_act(64'd256);
        wait_drain(31 * 17 - 17, "drain_one");
        chk("full_wr_ready_back", wr_ready, 1'b1);
        write_words(8'(30 * 17), 2, 17, 17);
        for (int i = 1; i < 31; i++) put_act(64'(256 + 2 * i));
        wait_drain(0, "drain_full");

        // Fill the descriptor queue with one-word packets
        rd_ready = 1'b0;
        for (int i = 0; i < 32; i++) put_pkt(8'(8'hC0 + i), 1, 64'(512 + 2 * i));
        chk("desc_pkt_count", pkt_count, 6'd32);
        chk("desc_wr_ready", wr_ready, 1'b0);
        rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) put_act(64'(512 + 2 * i));
        wait_drain(0, "drain_desc");

        // Asynchronous reset mid-packet
        rd_ready = 1'b0;
        put_act(64'hF0);
        put_pkt(8'hE1, 2, 64'hF0);
        put_word(8'hF1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_flags", {rd_valid, rd_sop, rd_last}, 3'b000);
        chk("arst_rd_data", {rd_keep, rd_data}, 9'h000);
        chk("arst_rd_action", rd_action, 64'h0);
        chk("arst_counts", {pkt_count, drop_count}, 22'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        rd_ready = 1'b1;
        put_act(64'h3C);
        put_pkt(8'h5A, 3, 64'h3C);
        tick();
        wait_drain(0, "drain_after_rst");
        chk("end_pkt_count", pkt_count, 6'd0);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
